// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, exception codes and SR/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

endpackage

// File: rtl/cp0_req_gen.sv
// Combinational interrupt/exception request generation; interrupts win over
// the exception carried by the M-stage instruction.
module cp0_req_gen
    import cp0_pkg::*;
#(
    parameter int HW_INT_W = 6
) (
    input  logic [HW_INT_W-1:0] sr_im,
    input  logic                sr_exl,
    input  logic                sr_ie,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic [4:0]          m_exc_code,
    output logic                int_req,
    output logic                exc_req,
    output logic                req,
    output logic [4:0]          exc_code_sel
);

    assign int_req      = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req      = (m_exc_code != 5'd0) & ~sr_exl;
    assign req          = int_req | exc_req;
    assign exc_code_sel = int_req ? EXC_INT : m_exc_code;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) for the P7 MIPS core.
// Optional macro CP0_EPC_BYPASS_EN forwards an mtc0 EPC write to epc_out.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h4255_4141,
    parameter int          HW_INT_W   = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         m_pc,
    input  logic                m_bd,
    input  logic [4:0]          m_exc_code,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                eret,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [31:0]         epc_out,
    output logic                req
);

    logic [HW_INT_W-1:0] sr_im;
    logic                sr_exl;
    logic                sr_ie;
    logic                cause_bd;
    logic [HW_INT_W-1:0] cause_ip;
    logic [4:0]          cause_exc;
    logic [31:0]         epc;

    logic        int_req;
    logic        exc_req;
    logic [4:0]  exc_code_sel;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_base;
    logic [31:0] epc_next;
    logic        sr_wr;
    logic        epc_wr;
    logic        unused_bits;

    cp0_req_gen #(
        .HW_INT_W(HW_INT_W)
    ) u_req_gen (
        .sr_im       (sr_im),
        .sr_exl      (sr_exl),
        .sr_ie       (sr_ie),
        .hw_int      (hw_int),
        .m_exc_code  (m_exc_code),
        .int_req     (int_req),
        .exc_req     (exc_req),
        .req         (req),
        .exc_code_sel(exc_code_sel)
    );

    // Delay-slot faults restart at the branch; wraps below zero by design.
    assign epc_base = {m_pc[31:2], 2'b00};
    assign epc_next = m_bd ? epc_base - 32'd4 : epc_base;

    assign sr_wr       = we & ~req & (addr == CP0_SR);
    assign epc_wr      = we & ~req & (addr == CP0_EPC);
    assign unused_bits = ^{m_pc[1:0], int_req, exc_req};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= m_bd;
                cause_exc <= exc_code_sel;
                epc       <= epc_next;
            end else begin
                if (sr_wr) begin
                    sr_im  <= wdata[IM_LO +: HW_INT_W];
                    sr_exl <= wdata[EXL_BIT];
                    sr_ie  <= wdata[IE_BIT];
                end
                if (epc_wr)
                    epc <= wdata;
                // eret lands after a same-cycle SR write, so EXL always ends cleared.
                if (eret)
                    sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        sr_val                      = '0;
        sr_val[IM_LO +: HW_INT_W]   = sr_im;
        sr_val[EXL_BIT]             = sr_exl;
        sr_val[IE_BIT]              = sr_ie;
        cause_val                   = '0;
        cause_val[BD_BIT]           = cause_bd;
        cause_val[IP_LO +: HW_INT_W] = cause_ip;
        cause_val[EXC_HI:EXC_LO]    = cause_exc;
    end

    always_comb begin
        case (addr)
            CP0_SR:    rdata = sr_val;
            CP0_CAUSE: rdata = cause_val;
            CP0_EPC:   rdata = epc;
            CP0_PRID:  rdata = PRID_VALUE;
            default:   rdata = '0;
        endcase
    end

`ifdef CP0_EPC_BYPASS_EN
    assign epc_out = epc_wr ? wdata : epc;
`else
    assign epc_out = epc;
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit; follows CP0_EPC_BYPASS_EN if defined.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] m_pc;
    logic        m_bd;
    logic [4:0]  m_exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic        req;

    int total = 0;
    int bad   = 0;

    cp0_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_pc      (m_pc),
        .m_bd      (m_bd),
        .m_exc_code(m_exc_code),
        .hw_int    (hw_int),
        .eret      (eret),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .epc_out   (epc_out),
        .req       (req)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        addr = a;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rd(5'd12);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_sr got=%h want=%h", rdata, 32'h0); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", req); end
        total++; if (epc_out !== 32'h0) begin bad++; $display("FAIL rst_epc_out got=%h want=0", epc_out); end
        rd(5'd15);
        total++; if (rdata !== 32'h4255_4141) begin bad++; $display("FAIL prid got=%h want=%h", rdata, 32'h4255_4141); end
        cyc();
        reset_n = 1'b1;
        cyc();
        mtc0(5'd12, 32'h0000_FC03);
        mtc0(5'd14, 32'h1234_5678);
        rd(5'd12);
        total++; if (rdata !== 32'h0000_FC03) begin bad++; $display("FAIL pre_rst_sr got=%h want=%h", rdata, 32'h0000_FC03); end
        rd(5'd14);
        total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL pre_rst_epc got=%h want=%h", rdata, 32'h1234_5678); end
        // assert reset mid-cycle and look immediately
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL async_rst_epc got=%h want=0", rdata); end
        rd(5'd12);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL async_rst_sr got=%h want=0", rdata); end
        rd(5'd13);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL async_rst_cause got=%h want=0", rdata); end
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_interrupt();
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; m_pc = 32'h0000_3010; m_bd = 1'b0;
        #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL int_req got=%b want=1", req); end
        cyc();
        total++; if (req !== 1'b0) begin bad++; $display("FAIL int_exl_mask got=%b want=0", req); end
        rd(5'd14);
        total++; if (rdata !== 32'h0000_3010) begin bad++; $display("FAIL int_epc got=%h want=%h", rdata, 32'h0000_3010); end
        total++; if (epc_out !== 32'h0000_3010) begin bad++; $display("FAIL int_epc_out got=%h want=%h", epc_out, 32'h0000_3010); end
        rd(5'd13);
        total++; if (rdata !== 32'h0000_0400) begin bad++; $display("FAIL int_cause got=%h want=%h", rdata, 32'h0000_0400); end
        rd(5'd12);
        total++; if (rdata !== 32'h0000_0403) begin bad++; $display("FAIL int_sr got=%h want=%h", rdata, 32'h0000_0403); end
    endtask

    task automatic test_eret();
        // hw_int still pending but masked by EXL
        total++; if (req !== 1'b0) begin bad++; $display("FAIL eret_pre_req got=%b want=0", req); end
        eret = 1'b1;
        cyc();
        eret = 1'b0;
        #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL eret_unmask_req got=%b want=1", req); end
        rd(5'd12);
        total++; if (rdata !== 32'h0000_0401) begin bad++; $display("FAIL eret_sr got=%h want=%h", rdata, 32'h0000_0401); end
        rd(5'd14);
        total++; if (rdata !== 32'h0000_3010) begin bad++; $display("FAIL eret_epc got=%h want=%h", rdata, 32'h0000_3010); end
        hw_int = 6'b0;
        #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL eret_idle_req got=%b want=0", req); end
    endtask

    task automatic test_delay_slot();
        m_exc_code = 5'd12; m_bd = 1'b1; m_pc = 32'h0000_3024;
        #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL ds_req got=%b want=1", req); end
        cyc();
        m_exc_code = 5'd0; m_bd = 1'b0;
        rd(5'd14);
        total++; if (rdata !== 32'h0000_3020) begin bad++; $display("FAIL ds_epc got=%h want=%h", rdata, 32'h0000_3020); end
        rd(5'd13);
        total++; if (rdata !== 32'h8000_0030) begin bad++; $display("FAIL ds_cause got=%h want=%h", rdata, 32'h8000_0030); end
        rd(5'd12);
        total++; if (rdata !== 32'h0000_0403) begin bad++; $display("FAIL ds_sr got=%h want=%h", rdata, 32'h0000_0403); end
    endtask

    task automatic test_priority();
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; m_exc_code = 5'd10; m_pc = 32'h0000_3040; m_bd = 1'b0;
        we = 1'b1; addr = 5'd14; wdata = 32'hDEAD_BEEF; eret = 1'b1;
        #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL prio_req got=%b want=1", req); end
        cyc();
        we = 1'b0; eret = 1'b0; m_exc_code = 5'd0;
        rd(5'd14);
        total++; if (rdata !== 32'h0000_3040) begin bad++; $display("FAIL prio_epc got=%h want=%h", rdata, 32'h0000_3040); end
        rd(5'd13);
        total++; if (rdata !== 32'h0000_0400) begin bad++; $display("FAIL prio_cause got=%h want=%h", rdata, 32'h0000_0400); end
        rd(5'd12);
        total++; if (rdata !== 32'h0000_0403) begin bad++; $display("FAIL prio_sr got=%h want=%h", rdata, 32'h0000_0403); end
        hw_int = 6'b0;
        cyc();
    endtask

    task automatic test_epc_wrap();
        mtc0(5'd12, 32'h0000_0000);
        m_exc_code = 5'd4; m_pc = 32'h0000_0002; m_bd = 1'b1;
        #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL wrap_req got=%b want=1", req); end
        cyc();
        m_exc_code = 5'd0; m_bd = 1'b0;
        rd(5'd14);
        total++; if (rdata !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_epc got=%h want=%h", rdata, 32'hFFFF_FFFC); end
        rd(5'd13);
        total++; if (rdata !== 32'h8000_0010) begin bad++; $display("FAIL wrap_cause got=%h want=%h", rdata, 32'h8000_0010); end
    endtask

    task automatic test_mtc0_map();
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12);
        total++; if (rdata !== 32'h0000_FC03) begin bad++; $display("FAIL sr_mask got=%h want=%h", rdata, 32'h0000_FC03); end
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13);
        total++; if (rdata !== 32'h8000_0010) begin bad++; $display("FAIL cause_ro got=%h want=%h", rdata, 32'h8000_0010); end
        mtc0(5'd15, 32'h0);
        rd(5'd15);
        total++; if (rdata !== 32'h4255_4141) begin bad++; $display("FAIL prid_ro got=%h want=%h", rdata, 32'h4255_4141); end
        rd(5'd3);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unmapped got=%h want=0", rdata); end
        eret = 1'b1;
        mtc0(5'd12, 32'h0000_0403);
        eret = 1'b0;
        rd(5'd12);
        total++; if (rdata !== 32'h0000_0401) begin bad++; $display("FAIL eret_wr_sr got=%h want=%h", rdata, 32'h0000_0401); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL eret_wr_req got=%b want=0", req); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_now;
`ifdef CP0_EPC_BYPASS_EN
        exp_now = 32'h0000_3100;
`else
        exp_now = 32'hFFFF_FFFC;
`endif
        we = 1'b1; addr = 5'd14; wdata = 32'h0000_3100;
        #1;
        total++; if (epc_out !== exp_now) begin bad++; $display("FAIL byp_epc_out got=%h want=%h", epc_out, exp_now); end
        total++; if (rdata !== 32'hFFFF_FFFC) begin bad++; $display("FAIL byp_rdata got=%h want=%h", rdata, 32'hFFFF_FFFC); end
        cyc();
        we = 1'b0;
        #1;
        total++; if (epc_out !== 32'h0000_3100) begin bad++; $display("FAIL byp_after got=%h want=%h", epc_out, 32'h0000_3100); end
        total++; if (rdata !== 32'h0000_3100) begin bad++; $display("FAIL byp_rd_after got=%h want=%h", rdata, 32'h0000_3100); end
    endtask

    initial begin
        reset_n = 1'b0; m_pc = '0; m_bd = 1'b0; m_exc_code = '0; hw_int = '0;
        eret = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        #2;
        test_reset();
        test_interrupt();
        test_eret();
        test_delay_slot();
        test_priority();
        test_epc_wrap();
        test_mtc0_map();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
